// File: rtl/gpio_result_reader.sv
// Drains result words from the BRAM read port onto the GPIO input word, one word per
// processor ack toggle. Words are presented as {tgl, done, 0000, index, sign-extended data}.
module gpio_result_reader #(
    parameter int RAM_WIDTH  = 13,
    parameter int NB_ADDRESS = 10,
    parameter int NB_IMAGE   = 10,
    parameter int GPIO_D     = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NB_IMAGE-1:0]   i_imgLength,
    input  logic                  i_ack,
    input  logic [RAM_WIDTH-1:0]  i_memData,
    output logic [NB_ADDRESS-1:0] o_readAdd,
    output logic [GPIO_D-1:0]     o_gpioData,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int DATA_FIELD_W = 16;
    localparam int INDEX_LSB    = 16;
    localparam int INDEX_MSB    = 25;
    localparam int DONE_BIT     = 30;
    localparam int TGL_BIT      = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PRESENT,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic                    start_prev_reg;
    logic [NB_ADDRESS-1:0]   len_reg, len_next;
    logic [NB_ADDRESS-1:0]   addr_reg, addr_next;
    logic [RAM_WIDTH-1:0]    data_reg, data_next;
    logic [NB_ADDRESS-1:0]   index_reg, index_next;
    logic                    done_reg, done_next;
    logic                    tgl_reg, tgl_next;

    logic                    start_edge;
    logic [NB_ADDRESS-1:0]   len_in;
    logic [NB_ADDRESS-1:0]   len_last;

    // Word count is fitted to the address width; the address itself never wraps.
    generate
        if (NB_IMAGE >= NB_ADDRESS) begin : g_len_trunc
            assign len_in = i_imgLength[NB_ADDRESS-1:0];
        end else begin : g_len_ext
            assign len_in = {{(NB_ADDRESS-NB_IMAGE){1'b0}}, i_imgLength};
        end
    endgenerate

    assign start_edge = i_start & ~start_prev_reg;
    assign len_last   = len_reg - NB_ADDRESS'(1);

    always_ff @(posedge i_CLK) begin
        if (!i_reset) begin
            state_reg      <= ST_IDLE;
            // Tracks i_start during reset so a level held through reset is not seen as an edge.
            start_prev_reg <= i_start;
            len_reg        <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            index_reg      <= '0;
            done_reg       <= 1'b0;
            tgl_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= i_start;
            len_reg        <= len_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            index_reg      <= index_next;
            done_reg       <= done_next;
            tgl_reg        <= tgl_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        index_next = index_reg;
        done_next  = done_reg;
        tgl_next   = tgl_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    len_next = len_in;
                    // Aligning tgl with the current ack means nothing looks pending yet.
                    tgl_next = i_ack;
                    if (len_in == '0) begin
                        done_next  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        done_next  = 1'b0;
                        addr_next  = '0;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                data_next  = i_memData;
                index_next = addr_reg;
                tgl_next   = ~tgl_reg;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_ack == tgl_reg) begin
                    if (index_reg == len_last) begin
                        done_next  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        addr_next  = addr_reg + NB_ADDRESS'(1);
                        state_next = ST_FETCH;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bit-by-bit assembly of the GPIO word from the presentation registers.
    generate
        for (genvar gi = 0; gi < GPIO_D; gi++) begin : g_gpio_bit
            if (gi < DATA_FIELD_W) begin : g_data
                if (gi < RAM_WIDTH) begin : g_raw
                    assign o_gpioData[gi] = data_reg[gi];
                end else begin : g_sext
                    assign o_gpioData[gi] = data_reg[RAM_WIDTH-1];
                end
            end else if ((gi >= INDEX_LSB) && (gi <= INDEX_MSB) &&
                         (gi - INDEX_LSB < NB_ADDRESS)) begin : g_index
                assign o_gpioData[gi] = index_reg[gi-INDEX_LSB];
            end else if (gi == DONE_BIT) begin : g_done
                assign o_gpioData[gi] = done_reg;
            end else if (gi == TGL_BIT) begin : g_tgl
                assign o_gpioData[gi] = tgl_reg;
            end else begin : g_zero
                assign o_gpioData[gi] = 1'b0;
            end
        end
    endgenerate

    assign o_readAdd = addr_reg;
    assign o_done    = done_reg;
    assign o_busy    = (state_reg == ST_FETCH)   || (state_reg == ST_WAIT) ||
                       (state_reg == ST_PRESENT) || (state_reg == ST_HOLD);

endmodule

// File: tb/tb_gpio_result_reader.sv
// Directed bench for gpio_result_reader: a word table drives a BRAM model, and the
// processor side of the toggle handshake is played by tasks with hand-computed expectations.
module tb_gpio_result_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  len_in;
    logic        ack;
    logic [12:0] mem_data;
    logic [9:0]  read_add;
    logic [31:0] gpio;
    logic        busy;
    logic        done;

    logic [12:0] bram [0:1023];

    typedef struct {
        logic [12:0] word;
        logic [15:0] exp16;
    } vec_t;

    vec_t        vecs [10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat_exp  = 4;
    logic        tgl_model = 1'b0;
    logic [31:0] last_exp = '0;

    gpio_result_reader #(
        .RAM_WIDTH (13),
        .NB_ADDRESS(10),
        .NB_IMAGE  (10),
        .GPIO_D    (32)
    ) dut (
        .i_CLK      (clk),
        .i_reset    (rst_n),
        .i_start    (start),
        .i_imgLength(len_in),
        .i_ack      (ack),
        .i_memData  (mem_data),
        .o_readAdd  (read_add),
        .o_gpioData (gpio),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= bram[read_add];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_drain(input int len, input bit keep_high);
        len_in    = 10'(len);
        tgl_model = ack;
        start     = 1'b1;
        @(negedge clk);
        check("start_busy", 32'(busy), 32'(1));
        check("start_done_clr", 32'(done), 32'(0));
        if (!keep_high) start = 1'b0;
        lat_exp = 3;
    endtask

    task automatic get_word(input int k);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((gpio[31] == ack) && (cyc < 100));
        check("word_latency", 32'(cyc), 32'(lat_exp));
        tgl_model = ~tgl_model;
        last_exp  = {tgl_model, 1'b0, 4'b0000, 10'(k), vecs[k].exp16};
        $display("word %0d: gpio=0x%08h addr=%0d busy=%0b", k, gpio, read_add, busy);
        check("gpio_word", gpio, last_exp);
        check("read_addr", 32'(read_add), 32'(k));
        check("hold_busy", 32'(busy), 32'(1));
    endtask

    task automatic send_ack(input int delay);
        repeat (delay) @(negedge clk);
        ack     = tgl_model;
        lat_exp = 4;
    endtask

    task automatic finish_check();
        @(negedge clk);
        check("done_set", 32'(done), 32'(1));
        check("done_busy_low", 32'(busy), 32'(0));
        check("done_gpio_top", 32'(gpio[31:30]), 32'({tgl_model, 1'b1}));
    endtask

    task automatic expect_idle_for(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) seen++;
        end
        check(name, 32'(seen), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{13'h0005, 16'h0005};
        vecs[1] = '{13'h1FFF, 16'hFFFF};
        vecs[2] = '{13'h0FFF, 16'h0FFF};
        vecs[3] = '{13'h1000, 16'hF000};
        vecs[4] = '{13'h0000, 16'h0000};
        vecs[5] = '{13'h1555, 16'hF555};
        vecs[6] = '{13'h0AAA, 16'h0AAA};
        vecs[7] = '{13'h1001, 16'hF001};
        vecs[8] = '{13'h0800, 16'h0800};
        vecs[9] = '{13'h1234, 16'hF234};
        for (int i = 0; i < 1024; i++) bram[i] = 13'h0;
        for (int i = 0; i < 10; i++) bram[i] = vecs[i].word;

        // Reset with start and ack high.
        rst_n  = 1'b0;
        start  = 1'b1;
        ack    = 1'b1;
        len_in = 10'd3;
        repeat (2) @(negedge clk);
        $display("reset: gpio=0x%08h addr=%0d busy=%0b done=%0b", gpio, read_add, busy, done);
        check("rst_gpio", gpio, 32'h0);
        check("rst_addr", 32'(read_add), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        expect_idle_for("rst_no_drain", 6);
        check("rst_no_done", 32'(done), 32'(0));
        start = 1'b0;
        ack   = 1'b0;
        @(negedge clk);

        // len=0 completes immediately.
        len_in = 10'd0;
        start  = 1'b1;
        @(negedge clk);
        $display("len0: gpio=0x%08h addr=%0d busy=%0b done=%0b", gpio, read_add, busy, done);
        check("len0_done", 32'(done), 32'(1));
        check("len0_busy", 32'(busy), 32'(0));
        check("len0_gpio", gpio, 32'h4000_0000);
        start = 1'b0;
        expect_idle_for("len0_never_busy", 5);
        check("len0_addr", 32'(read_add), 32'(0));

        // Basic drain of three words, start held high throughout.
        start_drain(3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            get_word(k);
            send_ack(2);
        end
        finish_check();
        expect_idle_for("held_start_single", 10);
        start = 1'b0;
        @(negedge clk);

        // Slow ack on word 1.
        start_drain(3, 1'b0);
        get_word(0);
        send_ack(1);
        get_word(1);
        begin
            int bad_gpio, bad_addr, bad_busy;
            bad_gpio = 0;
            bad_addr = 0;
            bad_busy = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (gpio !== last_exp) bad_gpio++;
                if (read_add !== 10'd1) bad_addr++;
                if (busy !== 1'b1) bad_busy++;
            end
            check("slow_gpio_stable", 32'(bad_gpio), 32'(0));
            check("slow_addr_stable", 32'(bad_addr), 32'(0));
            check("slow_busy_held", 32'(bad_busy), 32'(0));
        end
        send_ack(0);
        get_word(2);
        send_ack(2);
        finish_check();

        // Start pulse while busy is ignored, original len kept.
        start_drain(4, 1'b0);
        get_word(0);
        send_ack(1);
        get_word(1);
        len_in = 10'd7;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_start_hold", 32'(busy), 32'(1));
        check("busy_start_gpio", gpio, last_exp);
        send_ack(0);
        for (int k = 2; k < 4; k++) begin
            get_word(k);
            send_ack(1);
        end
        finish_check();
        expect_idle_for("busy_start_no_redrain", 10);

        // Reset during word 4 of a 10-word drain, then restart with ack high.
        start_drain(10, 1'b0);
        for (int k = 0; k < 3; k++) begin
            get_word(k);
            send_ack(1);
        end
        get_word(3);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_gpio", gpio, 32'h0);
        check("mid_rst_addr", 32'(read_add), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", 32'(busy), 32'(0));
        start_drain(10, 1'b0);
        for (int k = 0; k < 10; k++) begin
            get_word(k);
            send_ack(2);
        end
        finish_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
